// File: rtl/ysyx_wbu_commit_if.sv
// ---------------------------------------------------------------------------
// wbu_pipe_if -- write-back/commit bundle from the commit stage to the rest
// of the core.
//
// Carries the registered record of the most recently retired ROB entry:
//   pc, npc                 : retired pc and its resolved next pc (XLEN bits)
//   sys_retire, jen, ben    : system-retire, jump and branch flags
//   fence_time, fence_i     : fence/time and fence.i flags
//   flush_pipe              : the retired entry requires a front-end redirect
//
// Modports:
//   out / master : driven by the commit stage
//   slave        : consumed by downstream logic (front end, CSR, perf)
// ---------------------------------------------------------------------------
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

interface wbu_pipe_if #(
  parameter int XLEN = `YSYX_XLEN
) ();

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  logic            sys_retire;
  logic            jen;
  logic            ben;
  logic            fence_time;
  logic            fence_i;
  logic            flush_pipe;

  modport out (
    output pc, npc, sys_retire, jen, ben, fence_time, fence_i, flush_pipe
  );

  modport master (
    output pc, npc, sys_retire, jen, ben, fence_time, fence_i, flush_pipe
  );

  modport slave (
    input pc, npc, sys_retire, jen, ben, fence_time, fence_i, flush_pipe
  );

endinterface : wbu_pipe_if

// File: rtl/ysyx_wbu_commit.sv
// ---------------------------------------------------------------------------
// ysyx_wbu_commit -- in-order commit stage.
//
// Retires the ROB head when rob_valid && rob_ready, registers the retired
// entry onto the wbu bundle one cycle later with a single-cycle commit_valid
// pulse, and decides whether the pipeline must be redirected.
//
// Ports:
//   clock, reset        : single clock, asynchronous active-high reset
//   rob_valid/rob_ready : retire handshake with the ROB head
//   rob_pc/npc/pnpc     : head pc, resolved next pc, predicted next pc
//   rob_jen/ben/sys/fence_i/fence_time : head entry flags
//   icache_flush_done   : single-cycle ack that the i-cache invalidate finished
//   wbu                 : registered record of the last retired entry
//   commit_valid        : wbu holds a newly retired entry this cycle
//   retire_cnt          : 64-bit retired-instruction counter (optional)
//
// Optional feature: define YSYX_COMMIT_PERF_EN to add the retire_cnt port
// and its counter. With the macro undefined the port does not exist and all
// other behaviour is unchanged.
//
// Control flow:
//   IDLE       : accepts the head every cycle it is valid.
//   FLUSH      : one bubble after a redirecting retire while upstream drains.
//   FENCE_WAIT : after a fence.i retire, hold until the i-cache reports the
//                invalidate is done (an ack in the first wait cycle counts).
// ---------------------------------------------------------------------------
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

module ysyx_wbu_commit #(
  parameter int XLEN = `YSYX_XLEN
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            rob_valid,
  output logic            rob_ready,
  input  logic [XLEN-1:0] rob_pc,
  input  logic [XLEN-1:0] rob_npc,
  input  logic [XLEN-1:0] rob_pnpc,
  input  logic            rob_jen,
  input  logic            rob_ben,
  input  logic            rob_sys,
  input  logic            rob_fence_i,
  input  logic            rob_fence_time,

  input  logic            icache_flush_done,

  wbu_pipe_if.out         wbu,
  output logic            commit_valid
`ifdef YSYX_COMMIT_PERF_EN
  ,
  output logic [63:0]     retire_cnt
`endif
);

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FLUSH      = 2'd1,
    S_FENCE_WAIT = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  // retire is derived straight from the state register rather than from
  // rob_ready so the handshake has no combinational path back into the FSM.
  logic retire;
  logic redirect;

  assign retire = rob_valid && (state_q == S_IDLE);

  // Any entry whose resolved path differs from what fetch assumed, or that
  // changes architectural context, forces the front end to restart.
  assign redirect = (rob_npc != rob_pnpc) || rob_sys || rob_fence_i ||
                    rob_fence_time;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rob_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rob_ready = 1'b1;
        if (retire && redirect) begin
          // fence.i needs the i-cache ack; every other redirect only needs
          // a single drain bubble.
          state_d = rob_fence_i ? S_FENCE_WAIT : S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      S_FENCE_WAIT: begin
        if (icache_flush_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Retired-entry record
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] pc_q,         pc_d;
  logic [XLEN-1:0] npc_q,        npc_d;
  logic            sys_retire_q, sys_retire_d;
  logic            jen_q,        jen_d;
  logic            ben_q,        ben_d;
  logic            fence_time_q, fence_time_d;
  logic            fence_i_q,    fence_i_d;
  logic            flush_pipe_q, flush_pipe_d;
  logic            commit_valid_q, commit_valid_d;

  always_comb begin
    pc_d           = pc_q;
    npc_d          = npc_q;
    sys_retire_d   = sys_retire_q;
    jen_d          = jen_q;
    ben_d          = ben_q;
    fence_time_d   = fence_time_q;
    fence_i_d      = fence_i_q;
    // Pulses: low on every cycle that does not retire.
    commit_valid_d = retire;
    flush_pipe_d   = retire && redirect;
    if (retire) begin
      pc_d         = rob_pc;
      npc_d        = rob_npc;
      sys_retire_d = rob_sys;
      jen_d        = rob_jen;
      ben_d        = rob_ben;
      fence_time_d = rob_fence_time;
      fence_i_d    = rob_fence_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q           <= '0;
      npc_q          <= '0;
      sys_retire_q   <= 1'b0;
      jen_q          <= 1'b0;
      ben_q          <= 1'b0;
      fence_time_q   <= 1'b0;
      fence_i_q      <= 1'b0;
      flush_pipe_q   <= 1'b0;
      commit_valid_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      npc_q          <= npc_d;
      sys_retire_q   <= sys_retire_d;
      jen_q          <= jen_d;
      ben_q          <= ben_d;
      fence_time_q   <= fence_time_d;
      fence_i_q      <= fence_i_d;
      flush_pipe_q   <= flush_pipe_d;
      commit_valid_q <= commit_valid_d;
    end
  end

  assign wbu.pc         = pc_q;
  assign wbu.npc        = npc_q;
  assign wbu.sys_retire = sys_retire_q;
  assign wbu.jen        = jen_q;
  assign wbu.ben        = ben_q;
  assign wbu.fence_time = fence_time_q;
  assign wbu.fence_i    = fence_i_q;
  assign wbu.flush_pipe = flush_pipe_q;
  assign commit_valid   = commit_valid_q;

  // -------------------------------------------------------------------------
  // Optional retired-instruction counter (wraps naturally at 2^64)
  // -------------------------------------------------------------------------
`ifdef YSYX_COMMIT_PERF_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) begin
      retire_cnt_d = retire_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule : ysyx_wbu_commit

// File: tb/tb_ysyx_wbu_commit.sv
// ---------------------------------------------------------------------------
// tb_ysyx_wbu_commit -- self-checking bench for ysyx_wbu_commit.
// Directed table of single retires, hand-written multi-cycle sequences
// (ack timing, reset during fence wait, streaming) and a randomized phase
// compared against a retire-level reference model.
// ---------------------------------------------------------------------------
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

module tb_ysyx_wbu_commit;

  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            rob_valid = 1'b0;
  logic            rob_ready;
  logic [XLEN-1:0] rob_pc = '0;
  logic [XLEN-1:0] rob_npc = '0;
  logic [XLEN-1:0] rob_pnpc = '0;
  logic            rob_jen = 1'b0;
  logic            rob_ben = 1'b0;
  logic            rob_sys = 1'b0;
  logic            rob_fence_i = 1'b0;
  logic            rob_fence_time = 1'b0;
  logic            icache_flush_done = 1'b0;
  logic            commit_valid;
`ifdef YSYX_COMMIT_PERF_EN
  logic [63:0]     retire_cnt;
`endif

  wbu_pipe_if #(.XLEN(XLEN)) wbu_bus ();

  always #5 clock = ~clock;

  ysyx_wbu_commit #(.XLEN(XLEN)) dut (
    .clock             (clock),
    .reset             (reset),
    .rob_valid         (rob_valid),
    .rob_ready         (rob_ready),
    .rob_pc            (rob_pc),
    .rob_npc           (rob_npc),
    .rob_pnpc          (rob_pnpc),
    .rob_jen           (rob_jen),
    .rob_ben           (rob_ben),
    .rob_sys           (rob_sys),
    .rob_fence_i       (rob_fence_i),
    .rob_fence_time    (rob_fence_time),
    .icache_flush_done (icache_flush_done),
    .wbu               (wbu_bus),
    .commit_valid      (commit_valid)
`ifdef YSYX_COMMIT_PERF_EN
    ,
    .retire_cnt        (retire_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] wbu_flags();
    return {wbu_bus.jen, wbu_bus.ben, wbu_bus.sys_retire, wbu_bus.fence_i, wbu_bus.fence_time};
  endfunction

  task automatic idle_inputs();
    rob_valid = 1'b0; rob_jen = 1'b0; rob_ben = 1'b0; rob_sys = 1'b0;
    rob_fence_i = 1'b0; rob_fence_time = 1'b0; icache_flush_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic [63:0] pc, npc, pnpc;
    logic        jen, ben, sys, fi, ft;
    int          ack_delay;   // fence.i: wait cycles before the ack is driven
    logic        exp_flush;
    int          exp_low;     // cycles rob_ready must stay low afterwards
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int low;
    @(negedge clock);
    chk({v.name, ":ready_before"}, rob_ready, 1);
    rob_pc = v.pc; rob_npc = v.npc; rob_pnpc = v.pnpc;
    rob_jen = v.jen; rob_ben = v.ben; rob_sys = v.sys;
    rob_fence_i = v.fi; rob_fence_time = v.ft;
    rob_valid = 1'b1; icache_flush_done = 1'b0;
    @(negedge clock);
    idle_inputs();
    chk({v.name, ":commit_valid"}, commit_valid, 1);
    chk({v.name, ":flush_pipe"}, wbu_bus.flush_pipe, v.exp_flush);
    chk({v.name, ":pc"}, wbu_bus.pc, v.pc);
    chk({v.name, ":npc"}, wbu_bus.npc, v.npc);
    chk({v.name, ":flags"}, wbu_flags(), {v.jen, v.ben, v.sys, v.fi, v.ft});
    low = 0;
    while (!rob_ready && low < 40) begin
      low++;
      icache_flush_done = v.fi && (low - 1 == v.ack_delay);
      @(negedge clock);
      icache_flush_done = 1'b0;
    end
    chk({v.name, ":ready_low_cycles"}, 64'(low), 64'(v.exp_low));
    @(negedge clock);
    chk({v.name, ":cv_pulse_end"}, {commit_valid, wbu_bus.flush_pipe}, 2'b00);
    chk({v.name, ":pc_held"}, wbu_bus.pc, v.pc);
    $display("VEC %s pc=%h flush=%0d low=%0d", v.name, v.pc, v.exp_flush, low);
  endtask

  // ---------------- reference model for random phase ----------------
  // Tracks "is the commit stage accepting?" in terms of why it is blocked:
  // a pending drain bubble or an outstanding i-cache invalidate.
  bit          m_accepting;
  bit          m_drain_pending;
  bit          m_icache_pending;
  bit          m_cv, m_flush;
  logic [63:0] m_pc, m_npc;
  logic [4:0]  m_flags;
  logic [63:0] m_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"plain",      64'h8000_0000, 64'h8000_0004, 64'h8000_0004, 0,0,0,0,0, 0, 1'b0, 0};
    vecs[1] = '{"mispredict", 64'h8000_0004, 64'h8000_0100, 64'h8000_0008, 0,1,0,0,0, 0, 1'b1, 1};
    vecs[2] = '{"jump_hit",   64'h8000_0100, 64'h8000_0200, 64'h8000_0200, 1,0,0,0,0, 0, 1'b0, 0};
    vecs[3] = '{"sys",        64'h8000_0200, 64'h8000_0204, 64'h8000_0204, 0,0,1,0,0, 0, 1'b1, 1};
    vecs[4] = '{"fence_time", 64'h8000_0204, 64'h8000_0208, 64'h8000_0208, 0,0,0,0,1, 0, 1'b1, 1};
    vecs[5] = '{"fence_i_d5", 64'h8000_0208, 64'h8000_020c, 64'h8000_020c, 0,0,0,1,0, 5, 1'b1, 6};
    vecs[6] = '{"fence_i_d0", 64'h8000_020c, 64'h8000_0210, 64'h8000_0210, 0,0,0,1,0, 0, 1'b1, 1};
    vecs[7] = '{"npc_msb",    64'h8000_0210, 64'h0000_0000_8000_0214, 64'h8000_0000_8000_0214, 0,0,0,0,0, 0, 1'b1, 1};

    // Reset state
    idle_inputs();
    #2;
    chk("reset:commit_valid", commit_valid, 0);
    chk("reset:pc", wbu_bus.pc, 0);
    chk("reset:flush_flags", {wbu_bus.flush_pipe, wbu_flags()}, 6'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("reset:ready_after_release", rob_ready, 1);
`ifdef YSYX_COMMIT_PERF_EN
    chk("reset:retire_cnt", retire_cnt, 0);
`endif

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Ack during the retire cycle is outside FENCE_WAIT and must be ignored.
    @(negedge clock);
    rob_pc = 64'h8000_1000; rob_npc = 64'h8000_1004; rob_pnpc = 64'h8000_1004;
    rob_fence_i = 1'b1; rob_valid = 1'b1; icache_flush_done = 1'b1;
    @(negedge clock);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      chk("early_ack:ready_low", rob_ready, 0);
      @(negedge clock);
    end
    icache_flush_done = 1'b1;
    @(negedge clock);
    icache_flush_done = 1'b0;
    chk("early_ack:ready_back", rob_ready, 1);
    $display("SEQ early_ack done");

    // Reset two cycles into FENCE_WAIT
    @(negedge clock);
    rob_pc = 64'h8000_2000; rob_npc = 64'h8000_2004; rob_pnpc = 64'h8000_2004;
    rob_fence_i = 1'b1; rob_valid = 1'b1;
    @(negedge clock);
    idle_inputs();
    chk("rst_fence:ready_w1", rob_ready, 0);
    @(negedge clock);
    chk("rst_fence:ready_w2", rob_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_fence:async_pc", wbu_bus.pc, 0);
    chk("rst_fence:async_flags", {commit_valid, wbu_bus.flush_pipe, wbu_flags()}, 7'd0);
    chk("rst_fence:async_ready", rob_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_fence:ready_release", rob_ready, 1);
    icache_flush_done = 1'b1;
    @(negedge clock);
    icache_flush_done = 1'b0;
    chk("rst_fence:stray_ack", {rob_ready, commit_valid}, 2'b10);
    $display("SEQ reset_in_fence_wait done");

    // Streaming: 8 back-to-back non-redirect retires
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clock);
      if (i > 0) begin
        chk("stream:cv", commit_valid, 1);
        chk("stream:pc", wbu_bus.pc, 64'h8000_0000 + 64'(4 * (i - 1)));
        chk("stream:flush", wbu_bus.flush_pipe, 0);
      end
      chk("stream:ready", rob_ready, 1);
      if (i < 8) begin
        rob_pc = 64'h8000_0000 + 64'(4 * i);
        rob_npc = rob_pc + 64'd4; rob_pnpc = rob_npc; rob_valid = 1'b1;
      end else begin
        rob_valid = 1'b0;
      end
    end
    @(negedge clock);
    chk("stream:cv_end", commit_valid, 0);
`ifdef YSYX_COMMIT_PERF_EN
    chk("stream:retire_cnt", retire_cnt, 8);
`endif
    $display("SEQ streaming 8 done");

    // Randomized phase against the reference model
    do_reset();
    m_accepting = 1; m_drain_pending = 0; m_icache_pending = 0;
    m_cv = 0; m_flush = 0; m_pc = '0; m_npc = '0; m_flags = '0; m_cnt = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit retire, redir;
      @(negedge clock);
      chk("rand:ready", rob_ready, m_accepting);
      chk("rand:cv", commit_valid, m_cv);
      chk("rand:flush", wbu_bus.flush_pipe, m_flush);
      chk("rand:pc", wbu_bus.pc, m_pc);
      chk("rand:npc", wbu_bus.npc, m_npc);
      chk("rand:flags", wbu_flags(), m_flags);
`ifdef YSYX_COMMIT_PERF_EN
      chk("rand:retire_cnt", retire_cnt, m_cnt);
`endif
      rob_valid = ($urandom_range(0, 3) != 0);
      rob_pc = {$urandom, $urandom & 32'hffff_fffc};
      rob_pnpc = rob_pc + 64'd4;
      rob_npc = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : rob_pnpc;
      rob_jen = ($urandom_range(0, 9) == 0);
      rob_ben = ($urandom_range(0, 9) == 0);
      rob_sys = ($urandom_range(0, 15) == 0);
      rob_fence_i = ($urandom_range(0, 15) == 0);
      rob_fence_time = ($urandom_range(0, 15) == 0);
      icache_flush_done = ($urandom_range(0, 3) == 0);

      retire = rob_valid && m_accepting;
      redir = (rob_npc != rob_pnpc) || rob_sys || rob_fence_i || rob_fence_time;
      m_cv = retire;
      m_flush = retire && redir;
      if (retire) begin
        m_pc = rob_pc; m_npc = rob_npc;
        m_flags = {rob_jen, rob_ben, rob_sys, rob_fence_i, rob_fence_time};
        m_cnt = m_cnt + 64'd1;
        $display("RETIRE pc=%h npc=%h redirect=%0d fence_i=%0d", rob_pc, rob_npc, redir, rob_fence_i);
      end
      if (!m_accepting) begin
        if (m_drain_pending) m_drain_pending = 0;
        else if (m_icache_pending && icache_flush_done) m_icache_pending = 0;
        m_accepting = !(m_drain_pending || m_icache_pending);
      end else if (retire && redir) begin
        m_icache_pending = rob_fence_i;
        m_drain_pending = !rob_fence_i;
        m_accepting = 0;
      end
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ysyx_wbu_commit

// File: doc/ysyx_wbu_commit.md
YSYX_WBU_COMMIT -- requirements
Module: ysyx_wbu_commit

Interface
REQ-001 SHALL have parameter XLEN, default `YSYX_XLEN, meaning architectural data/address width.
REQ-002 SHALL have port clock  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rob_valid  input  1  ROB head entry complete and ready to retire.
REQ-005 SHALL have port rob_ready  output  1  commit accepts head this cycle; retire happens when rob_valid && rob_ready.
REQ-006 SHALL have port rob_pc  input  XLEN  pc of head entry.
REQ-007 SHALL have port rob_npc  input  XLEN  resolved next pc of head entry.
REQ-008 SHALL have port rob_pnpc  input  XLEN  predicted next pc carried from decode.
REQ-009 SHALL have ports rob_jen, rob_ben, rob_sys, rob_fence_i, rob_fence_time  input  1 each  jump, branch, system-retire, fence.i and fence/time flags of head entry.
REQ-010 SHALL have port icache_flush_done  input  1  single-cycle ack that an instruction-cache invalidate has completed.
REQ-011 SHALL have port wbu  wbu_pipe_if.out  bundle  registered pc, npc, sys_retire, jen, ben, fence_time, fence_i and flush_pipe of the last retired entry.
REQ-012 SHALL have port commit_valid  output  1  wbu bundle holds a newly retired entry this cycle.
REQ-013 SHALL have port retire_cnt  output  64  retired-instruction count (present only under REQ-030).

Function
REQ-014 SHALL implement FSM states IDLE, FLUSH, FENCE_WAIT.
REQ-015 IDLE: rob_ready=1; FLUSH and FENCE_WAIT: rob_ready=0.
REQ-016 On retire, wbu fields and commit_valid SHALL be registered one cycle later (latency 1); commit_valid is a single-cycle pulse per retire.
REQ-017 wbu.npc SHALL equal rob_npc; wbu.pc, jen, ben, fence_time, fence_i, sys_retire SHALL equal the corresponding rob_* input captured at retire.
REQ-018 Redirect condition = (rob_npc != rob_pnpc) || rob_sys || rob_fence_i || rob_fence_time, full-XLEN compare.
REQ-019 wbu.flush_pipe SHALL be 1 in the same cycle as commit_valid iff redirect condition held for that entry; else 0.
REQ-020 IDLE + retire with redirect and !rob_fence_i -> FLUSH; FLUSH -> IDLE unconditionally next cycle (one-cycle bubble while upstream drains).
REQ-021 IDLE + retire with rob_fence_i -> FENCE_WAIT; stay until icache_flush_done=1, then -> IDLE next cycle.
REQ-022 icache_flush_done arriving in the same cycle FENCE_WAIT is entered SHALL be honoured (FENCE_WAIT lasts one cycle); icache_flush_done outside FENCE_WAIT SHALL be ignored.
REQ-023 IDLE + retire without redirect -> stay IDLE; back-to-back retires SHALL sustain one per cycle.
REQ-024 Non-retire cycles SHALL hold wbu fields stable and drive commit_valid=0, flush_pipe=0.
REQ-025 rob_* inputs SHALL be ignored whenever rob_ready=0.

Reset
REQ-026 reset SHALL asynchronously force state=IDLE, commit_valid=0, all wbu fields (including flush_pipe) to 0, retire_cnt=0.
REQ-027 Reset asserted in FLUSH or FENCE_WAIT SHALL abandon the operation; no pending flush or fence ack is remembered after release.
REQ-028 First cycle after reset release rob_ready SHALL be 1.

Configuration
REQ-029 Macro YSYX_COMMIT_PERF_EN SHALL select the performance counter.
REQ-030 Defined: retire_cnt increments by 1 per retire (rob_valid && rob_ready), wraps modulo 2^64. Undefined: retire_cnt port and counter absent; all other behaviour identical.

Verification
REQ-031 Plain retire: rob_pc=0x8000_0000, npc=pnpc=0x8000_0004, valid 1 cycle -> next cycle commit_valid=1, wbu.pc=0x8000_0000, wbu.npc=0x8000_0004, flush_pipe=0, state IDLE.
REQ-032 Mispredict: rob_ben=1, npc=0x8000_0100, pnpc=0x8000_0008 -> flush_pipe=1 with commit_valid, rob_ready=0 one cycle, then 1.
REQ-033 fence.i: rob_fence_i=1, icache_flush_done raised 5 cycles later -> wbu.fence_i=1 and flush_pipe=1 once, rob_ready=0 for 6 cycles, then 1; ack also tested in entry cycle.
REQ-034 Streaming: 8 consecutive non-redirect entries -> 8 commit_valid pulses on consecutive cycles, retire_cnt=8 (PERF_EN defined).
REQ-035 Reset mid-FENCE_WAIT: assert reset 2 cycles into wait -> all outputs 0 immediately, rob_ready=1 after release, later stray icache_flush_done ignored.
